// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - background pixel server constants and pipeline stage type
package bg_pkg;

  localparam int IMG_W       = 320;
  localparam int IMG_H       = 240;
  localparam int X_OFFSET    = 160;
  localparam int ADDR_W      = 17;
  localparam int PIX_W       = 4;
  localparam int SCROLL_STEP = 1;

  typedef struct packed {
    logic valid;
    logic draw;
  } stage_t;

endpackage

// File: rtl/bg_frame_tick.sv
// rtl/bg_frame_tick.sv - frame strobe synchroniser with single-cycle rising-edge tick
module bg_frame_tick (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  // sync[1:0] is the two-flop synchroniser, sync[2] the edge-detect history
  logic [2:0] sync;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], frame_clk};
    end
  end

  assign tick = sync[1] & ~sync[2];

endmodule

// File: rtl/bg_pixel_server.sv
// rtl/bg_pixel_server.sv - scrolled background ROM addressing with fixed 3-cycle response
module bg_pixel_server
  import bg_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic              scroll_en,
  input  logic              req_valid,
  input  logic [9:0]        req_x,
  input  logic [9:0]        req_y,
  input  logic              is_bg,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              rsp_valid,
  output logic [PIX_W-1:0]  rsp_pix,
  output logic              rsp_is_bg,
  output logic [8:0]        scroll_pos
);

  localparam logic [9:0]        IMG_W10  = 10'(IMG_W);
  localparam logic [9:0]        IMG_H10  = 10'(IMG_H);
  localparam logic [9:0]        X_OFF10  = 10'(X_OFFSET);
  localparam logic [9:0]        X_END10  = 10'(X_OFFSET + IMG_W);
  localparam logic [9:0]        STEP10   = 10'(SCROLL_STEP);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

  logic              tick;
  logic [9:0]        scroll_sum;
  logic [8:0]        scroll_next;
  logic [9:0]        x_rel;
  logic [9:0]        col_raw;
  logic [9:0]        col;
  logic              in_range;
  logic [ADDR_W-1:0] addr;
  stage_t            s1;
  stage_t            s2;

  bg_frame_tick u_frame_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  always_comb begin
    scroll_sum  = {1'b0, scroll_pos} + STEP10;
    scroll_next = scroll_sum[8:0];
    if (scroll_sum >= IMG_W10) begin
      scroll_next = 9'(scroll_sum - IMG_W10);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scroll_pos <= '0;
    end else if (tick && scroll_en) begin
      scroll_pos <= scroll_next;
    end
  end

  // Column sum is at most 638 for an in-range request, so one subtract wraps it.
  always_comb begin
    in_range = (req_x >= X_OFF10) && (req_x < X_END10) && (req_y < IMG_H10);
    x_rel    = req_x - X_OFF10;
    col_raw  = x_rel + {1'b0, scroll_pos};
    col      = col_raw;
    if (col_raw >= IMG_W10) begin
      col = col_raw - IMG_W10;
    end
    addr = {{(ADDR_W-10){1'b0}}, req_y} * IMG_W_A + {{(ADDR_W-10){1'b0}}, col};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      s1        <= '0;
      s2        <= '0;
      rsp_valid <= 1'b0;
      rsp_pix   <= '0;
      rsp_is_bg <= 1'b0;
    end else begin
      if (req_valid && in_range) begin
        rom_addr <= addr;
      end
      s1.valid  <= req_valid;
      s1.draw   <= in_range && is_bg;
      s2        <= s1;
      rsp_valid <= s2.valid;
      rsp_pix   <= s2.draw ? rom_data : '0;
      rsp_is_bg <= s2.draw;
    end
  end

endmodule

// File: tb/tb_bg_pixel_server.sv
// tb/tb_bg_pixel_server.sv - directed self-checking bench for bg_pixel_server
module tb_bg_pixel_server;
  import bg_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_clk = 1'b0;
  logic              scroll_en = 1'b0;
  logic              req_valid = 1'b0;
  logic [9:0]        req_x = '0;
  logic [9:0]        req_y = '0;
  logic              is_bg = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data = '0;
  logic              rsp_valid;
  logic [PIX_W-1:0]  rsp_pix;
  logic              rsp_is_bg;
  logic [8:0]        scroll_pos;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_scroll = 0;
  int exp_rom_addr = 0;

  typedef struct {
    int pix;
    int bg;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  bg_pixel_server dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .scroll_en  (scroll_en),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .is_bg      (is_bg),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rsp_valid  (rsp_valid),
    .rsp_pix    (rsp_pix),
    .rsp_is_bg  (rsp_is_bg),
    .scroll_pos (scroll_pos)
  );

  always #10 Clk = ~Clk;

  function automatic logic [3:0] rom_fn(logic [16:0] a);
    return a[3:0] ^ a[11:8] ^ 4'h5;
  endfunction

  function automatic bit in_rng(int x, int y);
    return (x >= 160) && (x < 480) && (y < 240);
  endfunction

  function automatic int model_addr(int x, int y, int s);
    return y * 320 + ((x - 160 + s) % 320);
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          mon_e = q.pop_front();
          check("rsp_pix", rsp_pix, mon_e.pix);
          check("rsp_is_bg", rsp_is_bg, mon_e.bg);
          check("latency", cyc - mon_e.cyc, 3);
        end
      end else if (q.size() > 0 && (cyc - q[0].cyc) >= 3) begin
        check("missing_rsp", rsp_valid, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic req_one(int x, int y, bit bg);
    exp_t e;
    bit   ir;
    req_valid = 1'b1;
    req_x     = 10'(x);
    req_y     = 10'(y);
    is_bg     = bg;
    ir        = in_rng(x, y);
    if (ir) exp_rom_addr = model_addr(x, y, exp_scroll);
    e.pix = (ir && bg) ? int'(rom_fn(17'(exp_rom_addr))) : 0;
    e.bg  = (ir && bg) ? 1 : 0;
    e.cyc = cyc;
    q.push_back(e);
    @(posedge Clk); #1;
    check("rom_addr", rom_addr, exp_rom_addr);
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_tick();
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    if (scroll_en) exp_scroll = (exp_scroll + 1) % 320;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with a request held active
    Reset_n = 1'b0;
    req_valid = 1'b1; req_x = 10'd160; req_y = 10'd0; is_bg = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_pix", rsp_pix, 0);
    check("rst_rsp_is_bg", rsp_is_bg, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_scroll", scroll_pos, 0);
    req_valid = 1'b0;
    Reset_n = 1'b1;
    idle(5);

    // address corners at scroll 0
    req_one(160, 0, 1);
    check("corner_lo", rom_addr, 0);
    idle(4);
    req_one(479, 239, 1);
    check("corner_hi", rom_addr, 76799);
    idle(4);

    // scroll advance and column wrap
    scroll_en = 1'b1;
    repeat (10) do_tick();
    check("scroll_10", scroll_pos, 10);
    req_one(470, 5, 1);
    check("col_wrap_addr", rom_addr, 1600);
    idle(4);
    repeat (309) do_tick();
    check("scroll_319", scroll_pos, 319);
    do_tick();
    check("scroll_wrap0", scroll_pos, 0);
    repeat (2) do_tick();
    scroll_en = 1'b0;
    do_tick();
    check("scroll_hold", scroll_pos, 2);
    check("scroll_model", scroll_pos, exp_scroll);

    // out-of-range and masked requests
    req_one(100, 10, 1);
    check("oor_x_hold", rom_addr, 1600);
    req_one(200, 250, 1);
    check("oor_y_hold", rom_addr, 1600);
    req_one(200, 10, 0);
    check("masked_addr", rom_addr, 3242);
    idle(5);

    // back-to-back stream across a full line
    for (int x = 0; x < 640; x++) req_one(x, 20, 1);
    idle(5);

    // tick coinciding with a request uses the old scroll
    scroll_en = 1'b1;
    frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    req_one(160, 0, 1);
    check("collide_addr", rom_addr, 2);
    check("collide_scroll", scroll_pos, 3);
    exp_scroll = 3;
    req_valid = 1'b0;
    frame_clk = 1'b0;
    idle(5);

    // reset with two requests in flight
    req_one(300, 30, 1);
    req_one(301, 30, 1);
    req_valid = 1'b0;
    Reset_n = 1'b0;
    q.delete();
    exp_scroll = 0;
    exp_rom_addr = 0;
    @(posedge Clk);
    #1;
    check("midrst_valid", rsp_valid, 0);
    check("midrst_scroll", scroll_pos, 0);
    check("midrst_addr", rom_addr, 0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle(6);
    check("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_pixel_server.md
Name: bg_pixel_server

Overview:
- Responder side of the background address path.
- Accepts per-pixel background requests (DrawX/DrawY plus the is_bg qualifier) from the pixel pipeline.
- Applies a frame-synchronous horizontal scroll, wraps the column into the 320-wide image, and drives the background ROM address.
- Returns the ROM palette index with a fixed 3-cycle latency and a valid flag. Sits between the draw logic and the background ROM, ahead of the colour mapper.

Parameters:
- IMG_W, 320, background image width in pixels
- IMG_H, 240, background image height in pixels
- X_OFFSET, 160, screen X where image column 0 starts
- ADDR_W, 17, ROM address width (IMG_W*IMG_H = 76800 entries)
- PIX_W, 4, ROM data width (palette index)
- SCROLL_STEP, 1, columns advanced per frame tick

Ports:
- Clk  input  1  50 MHz system clock
- Reset_n  input  1  asynchronous, active-low reset
- frame_clk  input  1  frame strobe (~60 Hz), asynchronous to Clk
- scroll_en  input  1  1 = advance scroll on each frame tick
- req_valid  input  1  request strobe, one pixel per cycle
- req_x  input  10  DrawX of request
- req_y  input  10  DrawY of request
- is_bg  input  1  pixel is not covered by ball/pipe
- rom_addr  output  ADDR_W  background ROM address (ROM has 1-cycle synchronous read)
- rom_data  input  PIX_W  ROM read data
- rsp_valid  output  1  response strobe
- rsp_pix  output  PIX_W  palette index; 0 when not drawable
- rsp_is_bg  output  1  response is a drawable background pixel
- scroll_pos  output  9  current scroll column, 0..IMG_W-1

Behaviour:
Reset (Reset_n low, async) clears rom_addr, rsp_valid, rsp_pix, rsp_is_bg, scroll_pos, all pipeline valids and the frame synchroniser.

Frame tick:
- frame_clk passes through a 2-FF synchroniser, then a rising-edge detect, giving a 1-cycle tick.
- On a tick with scroll_en=1: scroll_pos <= (scroll_pos + SCROLL_STEP) mod IMG_W, computed with explicit compare and subtract, no modulo operator.

Stage 0 (request cycle N):
- in_range = req_x >= X_OFFSET and req_x < X_OFFSET+IMG_W and req_y < IMG_H.
- col = req_x - X_OFFSET + scroll_pos, 10-bit; if col >= IMG_W then col -= IMG_W.
- addr = req_y*IMG_W + col, computed at ADDR_W bits.
- Registered at the end of cycle N: rom_addr <= addr only when req_valid and in_range; otherwise rom_addr holds.
- s1_valid <= req_valid; s1_draw <= in_range and is_bg.

Stage 1 (cycle N+1): rom_addr is visible; ROM registers rom_data. s2_valid/s2_draw follow.

Stage 2 (cycle N+2): rom_data is valid. Registered to the outputs:
- rsp_valid <= s2_valid
- rsp_pix <= s2_draw ? rom_data : 0
- rsp_is_bg <= s2_draw
- Outputs are visible at cycle N+3. Latency is exactly 3 cycles from req_valid to rsp_valid.

Throughput and ordering: one request per cycle with no stall; responses come back in request order.

Boundary conditions:
- Tick in the same cycle as a request: the request uses the pre-update scroll_pos.
- scroll_pos = IMG_W-1 plus a tick: wraps to 0.
- Column exactly IMG_W after the scroll add: wraps to 0.
- Out-of-range request: response still issued with rsp_pix=0 and rsp_is_bg=0.
- is_bg=0: response issued with rsp_pix=0 and rsp_is_bg=0; the ROM read is still performed.
- Reset mid-pipeline: in-flight responses are dropped and no rsp_valid follows after release.
- scroll_en=0: scroll_pos holds and ticks are ignored.

Decomposition:
- Package bg_pkg: IMG_W, IMG_H, X_OFFSET, ADDR_W, PIX_W constants; a typedef for the pipeline stage struct {valid, draw}.
- Sub-module bg_frame_tick: synchroniser plus rising-edge detect, with ports Clk, Reset_n, frame_clk, tick.

Test Plan:
- Reset: hold Reset_n=0 with req_valid=1 -> all outputs 0, scroll_pos=0; after release there is no rsp_valid until 3 cycles after the first request.
- Address corners, scroll 0: (160,0) -> rom_addr=0; (479,239) -> rom_addr=76799; rsp_valid 3 cycles after each request, rsp_pix equals the ROM model data.
- Scroll wrap: 10 ticks -> scroll_pos=10; (470,5) -> col wraps to 0, rom_addr=1600. 320 total ticks -> scroll_pos=0.
- Out-of-range and masking: (100,10), then (200,250), then (200,10) with is_bg=0 -> each gives rsp_valid=1, rsp_pix=0, rsp_is_bg=0; rom_addr unchanged for the two out-of-range requests.
- Streaming: 640 back-to-back requests on one line -> 640 in-order responses, no gaps, each exactly 3 cycles after its request.
- Tick/request collision and mid-pipeline reset: a tick in the same cycle as a request at (160,0) -> rom_addr uses the old scroll. Asserting Reset_n=0 with 2 requests in flight -> neither response appears.
